// File: rtl/ysyx_25020037_isram_if.sv
// AR/R read channel between the IFU refill path and the instruction SRAM.
// Master drives requests and rready; slave drives arready and the response.
interface ysyx_25020037_isram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_25020037_isram.sv
// Instruction SRAM read responder, one outstanding read, decode errors.
// YSYX_25020037_ISRAM_LFSR_EN: per-request delay from a 4-bit LFSR.
module ysyx_25020037_isram #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = $clog2(DEPTH_WORDS),
  parameter int          LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_25020037_isram_if.slave  bus,
  input  logic                  prog_we,
  input  logic [AW-1:0]         prog_addr,
  input  logic [31:0]           prog_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RESP
  } state_t;

  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  state_t      state;
  logic [31:0] addr_q;
  logic [3:0]  cnt;
  logic [3:0]  dly_m1;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] off;
  logic        oor;
  logic        mis;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;
  logic        ar_hs;

  assign ar_hs = bus.arvalid && bus.arready;
  assign busy  = (state != IDLE);

  // Addresses below the base wrap to huge offsets and fall out of range.
  always_comb begin
    off     = addr_q - ADDR_BASE;
    oor     = ({1'b0, off} >= SPAN);
    mis     = (addr_q[1:0] != 2'b00);
    rd_word = 32'h0;
    rd_resp = 2'b00;
    unique case (1'b1)
      oor: begin
        rd_word = 32'h0;
        rd_resp = 2'b11;
      end
      (!oor && mis): begin
        rd_word = 32'h0;
        rd_resp = 2'b10;
      end
      default: begin
        rd_word = mem[off[AW+1:2]];
        rd_resp = 2'b00;
      end
    endcase
  end

`ifdef YSYX_25020037_ISRAM_LFSR_EN
  logic [3:0] lfsr;

  assign dly_m1 = {1'b0, lfsr[2:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= 4'b1001;
    end else if (ar_hs) begin
      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
  end
`else
  assign dly_m1 = 4'(LATENCY - 1);
`endif

  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr_q      <= 32'h0;
      cnt         <= 4'h0;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= 32'h0;
      bus.rresp   <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          bus.arready <= 1'b1;
          if (ar_hs) begin
            addr_q      <= bus.araddr;
            cnt         <= dly_m1;
            bus.arready <= 1'b0;
            state       <= DELAY;
          end
        end
        DELAY: begin
          if (cnt == 4'h0) begin
            bus.rdata  <= rd_word;
            bus.rresp  <= rd_resp;
            bus.rvalid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'h1;
          end
        end
        RESP: begin
          if (bus.rready) begin
            bus.rvalid  <= 1'b0;
            bus.arready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
